// File: rtl/loader_pkg.sv
// Shared types and defaults for the control-store boot loader.
// Pure declarations: no logic, no latency, no flow control.
// Imported by control_store_loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } loader_state_t;

  localparam int DEFAULT_WORD_BYTES = 4;
  localparam int BOOT_ADDR_W        = 17;

endpackage

// File: rtl/store_ram.sv
// Control-store RAM: one write port, one registered read port, no reset.
// Latency: read data appears one cycle after the address; writes land on the clock edge.
// Backpressure: none, both ports accept every cycle.
module store_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/control_store_loader.sv
// Assembles the byte-serial boot image into control words, then serves them to the microsequencer.
// Latency: byte accepted in strobe cycle, word written one cycle later; reads have 1-cycle latency.
// Backpressure: none; an out-of-order or overflowing byte latches a sticky error instead.
module control_store_loader
  import loader_pkg::*;
#(
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
  parameter int DEPTH_LOG2 = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    N_BOOTED,
  input  logic [BOOT_ADDR_W-1:0]  BOOT_ADDR,
  input  logic [7:0]              BOOT_DATA,
  input  logic                    BOOT_N_WE,
  input  logic [DEPTH_LOG2-1:0]   RD_ADDR,
  output logic [8*WORD_BYTES-1:0] RD_DATA,
  output logic                    READY,
  output logic                    ERROR,
  output logic [DEPTH_LOG2:0]     WORDS_LOADED
);

  localparam int LB = $clog2(WORD_BYTES);
  localparam int AW = BOOT_ADDR_W;
  localparam int DW = 8 * WORD_BYTES;
  localparam logic [AW-1:0] LANE_MASK = AW'(WORD_BYTES - 1);
  localparam logic [AW-1:0] LAST_BYTE = AW'((1 << (LB + DEPTH_LOG2)) - 1);

  loader_state_t         state_q;
  logic                  we_q;
  logic                  exp_end_q;
  logic                  wr_en_q;
  logic                  rd_vld_q;
  logic                  ready_q;
  logic                  error_q;
  logic [AW-1:0]         exp_addr_q;
  logic [DEPTH_LOG2:0]   words_q;
  logic [DEPTH_LOG2-1:0] wr_addr_q;
  logic [DW-1:0]         asm_q;
  logic [DW-1:0]         ram_rd_dat;

  logic [AW-1:0] lane_bits;
  logic [AW-1:0] word_full;
  logic          accept;
  logic          bad_byte;
  logic          last_lane;
  logic          lane_zero;

  always_comb begin
    lane_bits = BOOT_ADDR & LANE_MASK;
    word_full = BOOT_ADDR >> LB;
    accept    = we_q && !BOOT_N_WE && N_BOOTED && (state_q == IDLE || state_q == LOAD);
    // exp_end_q catches a byte after the last legal one even if exp_addr wrapped to 0
    bad_byte  = (BOOT_ADDR != exp_addr_q) || ((word_full >> DEPTH_LOG2) != '0) || exp_end_q;
    last_lane = (lane_bits == LANE_MASK);
    lane_zero = ((exp_addr_q & LANE_MASK) == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      we_q       <= 1'b1;
      exp_end_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      exp_addr_q <= '0;
      words_q    <= '0;
      wr_addr_q  <= '0;
      asm_q      <= '0;
    end else begin
      we_q     <= BOOT_N_WE;
      wr_en_q  <= 1'b0;
      rd_vld_q <= (state_q == DONE);
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (bad_byte) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else begin
              state_q    <= LOAD;
              exp_addr_q <= exp_addr_q + 1'b1;
              exp_end_q  <= (exp_addr_q == LAST_BYTE);
              for (int k = 0; k < WORD_BYTES; k++) begin
                if (lane_bits == AW'(k)) asm_q[8*k +: 8] <= BOOT_DATA;
              end
              // asm_q already holds the full word when the RAM write fires next cycle
              if (last_lane) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= word_full[DEPTH_LOG2-1:0];
                words_q   <= words_q + 1'b1;
              end
            end
          end else if (!N_BOOTED) begin
            if (lane_zero) begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  store_ram #(
    .DATA_W(DW),
    .ADDR_W(DEPTH_LOG2)
  ) u_store_ram (
    .clk    (CLK),
    .wr_en  (wr_en_q),
    .wr_addr(wr_addr_q),
    .wr_dat (asm_q),
    .rd_addr(RD_ADDR),
    .rd_dat (ram_rd_dat)
  );

  assign RD_DATA      = rd_vld_q ? ram_rd_dat : '0;
  assign READY        = ready_q;
  assign ERROR        = error_q;
  assign WORDS_LOADED = words_q;

endmodule
